// File: rtl/johnson_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : johnson_step_ctrl                                                |
// | Brief   : Johnson counter stepped a requested number of times per run,     |
// |           with pause/abort, guarded parallel load and phase decode.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module johnson_step_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [4:0]                    steps,
  input  logic                          dir,
  input  logic                          pause,
  input  logic                          abort,
  input  logic                          load,
  input  logic [WIDTH-1:0]              load_val,
  output logic [WIDTH-1:0]              q,
  output logic [$clog2(2*WIDTH)-1:0]    phase,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int              PW      = $clog2(2*WIDTH);
  localparam logic [PW:0]     C_RING  = (PW+1)'(2*WIDTH);
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [4:0]       rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] load_inv;
  logic             load_ok;
  logic [WIDTH-1:0] q_fwd;
  logic [WIDTH-1:0] q_rev;
  logic [PW:0]      pop_cnt;
  logic [PW:0]      ring_minus;

  // Ring states are a run of ones anchored at bit 0, or at the MSB.
  assign load_inv = ~load_val;
  assign load_ok  = ((load_val & (load_val + C_ONE)) == '0) ||
                    ((load_inv & (load_inv + C_ONE)) == '0);

  assign q_fwd = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
  assign q_rev = {~q_q[0], q_q[WIDTH-1:1]};

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + {{PW{1'b0}}, q_q[i]};
    end
  end

  assign ring_minus = C_RING - pop_cnt;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          if (load_ok) begin
            q_d = load_val;
          end else begin
            q_d   = '0;
            err_d = 1'b1;
          end
        end else if (start) begin
          if (steps != 5'd0) begin
            state_d = ST_RUN;
            rem_d   = steps;
            dir_d   = dir;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          rem_d   = 5'd0;
        end else if (!pause) begin
          q_d   = dir_q ? q_rev : q_fwd;
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      rem_q   <= 5'd0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign q     = q_q;
  assign phase = q_q[WIDTH-1] ? ring_minus[PW-1:0] : pop_cnt[PW-1:0];
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_johnson_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_johnson_step_ctrl                                             |
// | Brief   : Scoreboard bench for johnson_step_ctrl, phase-based model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_johnson_step_ctrl;

  localparam int W    = 8;
  localparam int RING = 2*W;

  logic         clk = 1'b0;
  logic         reset, start, dir, pause, abort, load;
  logic [4:0]   steps;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic [3:0]   phase;
  logic         busy, done, err;

  johnson_step_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .steps(steps), .dir(dir),
    .pause(pause), .abort(abort), .load(load), .load_val(load_val),
    .q(q), .phase(phase), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [3:0]   ph;
    logic         b;
    logic         d;
    logic         e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;

  // Model state: position on the ring plus run bookkeeping.
  int m_ph = 0, m_mode = 0, m_rem = 0, m_dir = 0, m_err = 0;

  function automatic logic [W-1:0] code_of(int ph);
    logic [31:0] t;
    if (ph <= W) t = (32'd1 << ph) - 32'd1;
    else         t = ~((32'd1 << (ph - W)) - 32'd1);
    return t[W-1:0];
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   found;
    if (reset) begin
      m_ph = 0; m_mode = 0; m_rem = 0; m_dir = 0; m_err = 0;
    end else begin
      case (m_mode)
        0: begin
          if (load) begin
            found = -1;
            for (int k = 0; k < RING; k++) if (code_of(k) == load_val) found = k;
            if (found >= 0) m_ph = found;
            else begin m_ph = 0; m_err = 1; end
          end else if (start) begin
            if (steps != 0) begin m_mode = 1; m_rem = steps; m_dir = dir; end
            else m_mode = 2;
          end
        end
        1: begin
          if (abort) m_mode = 0;
          else if (!pause) begin
            m_ph  = m_dir ? (m_ph + RING - 1) % RING : (m_ph + 1) % RING;
            m_rem = m_rem - 1;
            if (m_rem == 0) m_mode = 2;
          end
        end
        default: m_mode = 0;
      endcase
    end
    e.q  = code_of(m_ph);
    e.ph = 4'(m_ph);
    e.b  = (m_mode == 1);
    e.d  = (m_mode == 2);
    e.e  = m_err[0];
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: DUT output with no expected entry at %0t", $time);
    end else begin
      e = sb.pop_front();
      if (q !== e.q || phase !== e.ph || busy !== e.b || done !== e.d || err !== e.e) begin
        errors++;
        $display("FAIL cycle @%0t: got q=%h ph=%0d b=%b d=%b e=%b, expected q=%h ph=%0d b=%b d=%b e=%b",
                 $time, q, phase, busy, done, err, e.q, e.ph, e.b, e.d, e.e);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    start = 0; load = 0; pause = 0; abort = 0;
  endtask

  task automatic cyc(int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_load(logic [W-1:0] v);
    load = 1; load_val = v;
    @(negedge clk);
    load = 0;
  endtask

  task automatic do_run(int s, logic d, int wait_cycles);
    start = 1; steps = 5'(s); dir = d;
    @(negedge clk);
    start = 0;
    cyc(wait_cycles);
  endtask

  initial begin
    int d0, b0;
    reset = 1; idle_in(); steps = 0; dir = 0; load_val = 0;
    cyc(2);
    reset = 0;
    chk("reset_q", 32'(q), 0);
    chk("reset_err", 32'(err), 0);

    d0 = done_cnt;
    do_run(3, 0, 5);
    chk("fwd3_q", 32'(q), 32'h07);
    chk("fwd3_phase", 32'(phase), 3);
    chk("fwd3_done", done_cnt - d0, 1);

    do_run(5, 1, 7);
    chk("rev5_q", 32'(q), 32'hC0);
    chk("rev5_phase", 32'(phase), 14);

    do_load(8'h00);
    d0 = done_cnt;
    do_run(17, 0, 20);
    chk("wrap17_q", 32'(q), 32'h01);
    chk("wrap17_done", done_cnt - d0, 1);

    do_load(8'h00);
    b0 = busy_cnt;
    start = 1; steps = 5'd6; dir = 0;
    @(negedge clk); start = 0;          // RUN cycle 1
    @(negedge clk); pause = 1;          // RUN cycle 2
    @(negedge clk);                     // RUN cycle 3
    @(negedge clk); pause = 0;
    cyc(8);
    chk("pause_busy", busy_cnt - b0, 8);
    chk("pause_q", 32'(q), 32'h3F);

    do_load(8'h00);
    d0 = done_cnt;
    start = 1; steps = 5'd10; dir = 0;
    @(negedge clk); start = 0;
    cyc(3);
    abort = 1;
    @(negedge clk); abort = 0;
    chk("abort_busy", 32'(busy), 0);
    cyc(2);
    chk("abort_q", 32'(q), 32'h07);
    chk("abort_nodone", done_cnt - d0, 0);

    do_load(8'h0F);
    chk("load_q", 32'(q), 32'h0F);
    chk("load_phase", 32'(phase), 4);
    chk("load_err", 32'(err), 0);
    do_load(8'h05);
    chk("badload_q", 32'(q), 0);
    chk("badload_err", 32'(err), 1);
    start = 1; steps = 5'd20; dir = 0;
    @(negedge clk); start = 0;
    cyc(4);
    reset = 1;
    @(negedge clk); reset = 0;
    chk("midrst_q", 32'(q), 0);
    chk("midrst_phase", 32'(phase), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_err", 32'(err), 0);

    for (int n = 0; n < 3000; n++) begin
      start    = ($urandom_range(0, 3) == 0);
      load     = ($urandom_range(0, 7) == 0);
      pause    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 63) == 0);
      steps    = 5'($urandom_range(0, 31));
      dir      = 1'($urandom_range(0, 1));
      load_val = $urandom_range(0, 1) ? code_of($urandom_range(0, RING-1)) : W'($urandom);
      @(negedge clk);
    end
    idle_in(); reset = 0;
    cyc(2);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
